// File: rtl/regfile_pkg.sv
// Shared defaults and helpers for the multi-port register file.
package regfile_pkg;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 3;
  localparam logic [63:0] RST_VAL = '0;

  function automatic int numRegs(input int addrW);
    return 1 << addrW;
  endfunction
endpackage

// File: rtl/regfile_bypass.sv
// Write-first forwarding mux for one read port; REGFILE_R0_ZERO_EN forces reads of address 0 to zero.
module regfile_bypass
  import regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic [ADDR_W-1:0] sel,
  input  logic [DATA_W-1:0] stored,
  input  logic              we0,
  input  logic [ADDR_W-1:0] selD0,
  input  logic [DATA_W-1:0] dataD0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] selD1,
  input  logic [DATA_W-1:0] dataD1,
  output logic [DATA_W-1:0] dataOut
);
  always_comb begin
    dataOut = stored;
    if (we0 && (selD0 == sel)) dataOut = dataD0;
    // port 1 checked last so it wins a same-address conflict
    if (we1 && (selD1 == sel)) dataOut = dataD1;
`ifdef REGFILE_R0_ZERO_EN
    if (sel == '0) dataOut = '0;
`endif
  end
endmodule

// File: rtl/reg_file_mp.sv
// Two-write / two-read register file with registered reads and write-first bypass.
// Optional REGFILE_R0_ZERO_EN hard-wires register 0 to zero.
module reg_file_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              I_clk,
  input  logic              I_rst_n,
  input  logic              I_en,
  input  logic              I_we0,
  input  logic [ADDR_W-1:0] I_selD0,
  input  logic [DATA_W-1:0] I_dataD0,
  input  logic              I_we1,
  input  logic [ADDR_W-1:0] I_selD1,
  input  logic [DATA_W-1:0] I_dataD1,
  input  logic [ADDR_W-1:0] I_selA,
  input  logic [ADDR_W-1:0] I_selB,
  output logic [DATA_W-1:0] O_dataA,
  output logic [DATA_W-1:0] O_dataB,
  output logic              O_valid
);
  localparam int NUM_REGS = numRegs(ADDR_W);
  localparam int NUM_RD   = 2;

  logic [NUM_REGS-1:0][DATA_W-1:0] regs;
  logic [NUM_RD-1:0][ADDR_W-1:0]   rdSel;
  logic [NUM_RD-1:0][DATA_W-1:0]   rdEff;
  logic [NUM_RD-1:0][DATA_W-1:0]   rdQ;
  logic                            validQ;
  logic                            wrOk0, wrOk1;

`ifdef REGFILE_R0_ZERO_EN
  assign wrOk0 = I_we0 && (I_selD0 != '0);
  assign wrOk1 = I_we1 && (I_selD1 != '0);
`else
  assign wrOk0 = I_we0;
  assign wrOk1 = I_we1;
`endif

  assign rdSel[0] = I_selA;
  assign rdSel[1] = I_selB;

  for (genvar p = 0; p < NUM_RD; p++) begin : gRd
    regfile_bypass #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) uByp (
      .sel    (rdSel[p]),
      .stored (regs[rdSel[p]]),
      .we0    (I_we0),
      .selD0  (I_selD0),
      .dataD0 (I_dataD0),
      .we1    (I_we1),
      .selD1  (I_selD1),
      .dataD1 (I_dataD1),
      .dataOut(rdEff[p])
    );
  end

  always_ff @(posedge I_clk) begin
    if (!I_rst_n) begin
      for (int r = 0; r < NUM_REGS; r++) regs[r] <= RST_VAL[DATA_W-1:0];
      rdQ    <= '0;
      validQ <= 1'b0;
    end else if (I_en) begin
      if (wrOk0) regs[I_selD0] <= I_dataD0;
      if (wrOk1) regs[I_selD1] <= I_dataD1;
      rdQ    <= rdEff;
      validQ <= 1'b1;
    end else begin
      validQ <= 1'b0;
    end
  end

  assign O_dataA = rdQ[0];
  assign O_dataB = rdQ[1];
  assign O_valid = validQ;
endmodule

// File: tb/tb_reg_file_mp.sv
// Directed bench for reg_file_mp; expectations follow REGFILE_R0_ZERO_EN when defined.
module tb_reg_file_mp;
  logic        I_clk = 1'b0;
  logic        I_rst_n, I_en, I_we0, I_we1;
  logic [2:0]  I_selD0, I_selD1, I_selA, I_selB;
  logic [15:0] I_dataD0, I_dataD1;
  logic [15:0] O_dataA, O_dataB;
  logic        O_valid;
  int checks = 0;
  int errors = 0;

`ifdef REGFILE_R0_ZERO_EN
  localparam bit R0Z = 1'b1;
`else
  localparam bit R0Z = 1'b0;
`endif

  always #5 I_clk = ~I_clk;

  reg_file_mp dut (
    .I_clk(I_clk), .I_rst_n(I_rst_n), .I_en(I_en),
    .I_we0(I_we0), .I_selD0(I_selD0), .I_dataD0(I_dataD0),
    .I_we1(I_we1), .I_selD1(I_selD1), .I_dataD1(I_dataD1),
    .I_selA(I_selA), .I_selB(I_selB),
    .O_dataA(O_dataA), .O_dataB(O_dataB), .O_valid(O_valid)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // apply one cycle of inputs, then settle past the edge
  task automatic cyc(input logic rst_n, input logic en,
                     input logic we0, input logic [2:0] s0, input logic [15:0] d0,
                     input logic we1, input logic [2:0] s1, input logic [15:0] d1,
                     input logic [2:0] sa, input logic [2:0] sb);
    I_rst_n = rst_n; I_en = en;
    I_we0 = we0; I_selD0 = s0; I_dataD0 = d0;
    I_we1 = we1; I_selD1 = s1; I_dataD1 = d1;
    I_selA = sa; I_selB = sb;
    @(posedge I_clk);
    #1;
  endtask

  initial begin
    // initial reset, then dirty reg 0, then reset with a pending write
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 1, 0, 16'hFFFF, 0, 0, 0, 0, 0);
    cyc(0, 1, 1, 1, 16'h1234, 1, 0, 16'h5678, 0, 1);
    chk("rst_dataA", O_dataA, 16'h0000);
    chk("rst_dataB", O_dataB, 16'h0000);
    chk("rst_valid", {15'd0, O_valid}, 16'h0000);
    for (int r = 0; r < 8; r += 2) begin
      cyc(1, 1, 0, 0, 0, 0, 0, 0, 3'(r), 3'(r + 1));
      chk("rst_readA", O_dataA, 16'h0000);
      chk("rst_readB", O_dataB, 16'h0000);
      chk("rst_read_valid", {15'd0, O_valid}, 16'h0001);
    end

    // basic write then read
    cyc(1, 1, 1, 2, 16'h2222, 0, 0, 0, 7, 7);
    cyc(1, 1, 0, 0, 0, 0, 0, 0, 2, 1);
    chk("basic_A", O_dataA, 16'h2222);
    chk("basic_B", O_dataB, 16'h0000);
    chk("basic_valid", {15'd0, O_valid}, 16'h0001);

    // port 1 bypass to both read ports
    cyc(1, 1, 0, 0, 0, 1, 3, 16'h3333, 3, 3);
    chk("byp1_A", O_dataA, 16'h3333);
    chk("byp1_B", O_dataB, 16'h3333);

    // port 0 bypass
    cyc(1, 1, 1, 6, 16'h6666, 0, 0, 0, 6, 2);
    chk("byp0_A", O_dataA, 16'h6666);
    chk("byp0_B", O_dataB, 16'h2222);

    // write conflict: port 1 wins, bypassed and stored
    cyc(1, 1, 1, 4, 16'hFEED, 1, 4, 16'h4444, 4, 6);
    chk("conf_byp", O_dataA, 16'h4444);
    chk("conf_other", O_dataB, 16'h6666);
    cyc(1, 1, 0, 0, 0, 0, 0, 0, 3, 4);
    chk("conf_stored", O_dataB, 16'h4444);
    chk("byp1_stored", O_dataA, 16'h3333);

    // enable gating: no write, outputs hold, valid drops
    cyc(1, 1, 0, 0, 0, 0, 0, 0, 5, 3);
    chk("pre_en_A", O_dataA, 16'h0000);
    cyc(1, 0, 1, 5, 16'hBEEF, 1, 2, 16'hDEAD, 'x, 'x);
    chk("en0_holdA", O_dataA, 16'h0000);
    chk("en0_holdB", O_dataB, 16'h3333);
    chk("en0_valid", {15'd0, O_valid}, 16'h0000);
    cyc(1, 1, 0, 0, 0, 0, 0, 0, 5, 2);
    chk("en0_reg5", O_dataA, 16'h0000);
    chk("en0_reg2", O_dataB, 16'h2222);
    chk("en1_valid", {15'd0, O_valid}, 16'h0001);

    // register 0 behaviour
    cyc(1, 1, 1, 0, 16'hFFFF, 0, 0, 0, 0, 1);
    chk("r0_byp", O_dataA, R0Z ? 16'h0000 : 16'hFFFF);
    cyc(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("r0_storedA", O_dataA, R0Z ? 16'h0000 : 16'hFFFF);
    chk("r0_storedB", O_dataB, R0Z ? 16'h0000 : 16'hFFFF);
    cyc(1, 1, 1, 0, 16'h1111, 1, 0, 16'h2222, 0, 4);
    chk("r0_conf_byp", O_dataA, R0Z ? 16'h0000 : 16'h2222);
    cyc(1, 1, 0, 0, 0, 0, 0, 0, 0, 4);
    chk("r0_conf_stored", O_dataA, R0Z ? 16'h0000 : 16'h2222);
    chk("reg4_final", O_dataB, 16'h4444);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
